// File: rtl/vga_pkg.sv
// Shared raster constants and coordinate type for the display path.
package vga_pkg;

  localparam int unsigned COORD_W   = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/vga_sync_decode.sv
// Combinational map from raster coordinates to visible flag and sync levels.
module vga_sync_decode
  import vga_pkg::coord_t;
  import vga_pkg::COORD_W;
#(
  parameter int unsigned H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT     = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
  parameter int unsigned V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT     = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  coord_t x_i,
  input  coord_t y_i,
  output logic   blank_c,
  output logic   hs_c,
  output logic   vs_c
);

  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  always_comb begin
    blank_c = (x_i < COORD_W'(H_VISIBLE)) && (y_i < COORD_W'(V_VISIBLE));
    hs_c    = ((x_i >= COORD_W'(HS_START)) && (x_i < COORD_W'(HS_END))) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_c    = ((y_i >= COORD_W'(VS_START)) && (y_i < COORD_W'(VS_END))) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe, scan counters, registered blank/sync, pulses.
// Optional 16-bit completed-frame counter when FRAME_CNT_EN is defined.
module vga_timing_gen
  import vga_pkg::coord_t;
  import vga_pkg::COORD_W;
#(
  parameter int unsigned H_VISIBLE   = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT     = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK      = vga_pkg::H_BACK,
  parameter int unsigned V_VISIBLE   = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT     = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK      = vga_pkg::V_BACK,
  parameter int unsigned CLK_DIV     = 2,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic       CLK,
  input  logic       Reset_n,
  output logic       pixel_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       hs_d,
  output logic       vs_d,
  output logic       line_start,
  output logic       frame_start
`ifdef FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned DIV_W   = 2;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic [DIV_W-1:0] div_q, div_d;
  logic             pen_q, pen_d;
  coord_t           x_q, x_d, y_q, y_d;
  logic             blank_q, blank_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             hsync_dly_q, vsync_dly_q;
  logic             line_q, line_d, frame_q, frame_d;
  logic             fresh_q;
  logic             div_last_c, x_last_c, y_last_c;

  assign div_last_c = (div_q == DIV_W'(CLK_DIV - 1));
  assign x_last_c   = (x_q == COORD_W'(H_TOTAL - 1));
  assign y_last_c   = (y_q == COORD_W'(V_TOTAL - 1));

  // fresh_q marks the first edge after reset so (0,0) gets its line/frame pulses.
  always_comb begin
    div_d   = div_last_c ? '0 : div_q + DIV_W'(1);
    pen_d   = div_last_c;
    x_d     = x_q;
    y_d     = y_q;
    if (pen_q) begin
      if (x_last_c) begin
        x_d = '0;
        y_d = y_last_c ? '0 : y_q + COORD_W'(1);
      end else begin
        x_d = x_q + COORD_W'(1);
      end
    end
    line_d  = fresh_q | (pen_q & x_last_c);
    frame_d = fresh_q | (pen_q & x_last_c & y_last_c);
  end

  // Decode from next-state counters so blank/sync land on the same edge as DrawX/DrawY.
  vga_sync_decode #(
    .H_VISIBLE  (H_VISIBLE),
    .H_FRONT    (H_FRONT),
    .H_SYNC     (H_SYNC),
    .V_VISIBLE  (V_VISIBLE),
    .V_FRONT    (V_FRONT),
    .V_SYNC     (V_SYNC),
    .SYNC_ACTIVE(SYNC_ACTIVE)
  ) u_decode (
    .x_i    (x_d),
    .y_i    (y_d),
    .blank_c(blank_d),
    .hs_c   (hsync_d),
    .vs_c   (vsync_d)
  );

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q       <= '0;
      pen_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      blank_q     <= 1'b0;
      hsync_q     <= ~SYNC_ACTIVE;
      vsync_q     <= ~SYNC_ACTIVE;
      hsync_dly_q <= ~SYNC_ACTIVE;
      vsync_dly_q <= ~SYNC_ACTIVE;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      fresh_q     <= 1'b1;
    end else begin
      div_q       <= div_d;
      pen_q       <= pen_d;
      x_q         <= x_d;
      y_q         <= y_d;
      blank_q     <= blank_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      hsync_dly_q <= hsync_q;
      vsync_dly_q <= vsync_q;
      line_q      <= line_d;
      frame_q     <= frame_d;
      fresh_q     <= 1'b0;
    end
  end

`ifdef FRAME_CNT_EN
  localparam int unsigned FCNT_W = 16;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  // Counts completed frames (wraps), not the start-up pulse.
  always_comb fcnt_d = (pen_q & x_last_c & y_last_c) ? fcnt_q + FCNT_W'(1) : fcnt_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) fcnt_q <= '0;
    else          fcnt_q <= fcnt_d;
  end

  assign frame_cnt = fcnt_q;
`else
  // No frame counter in this build.
`endif

  assign pixel_en    = pen_q;
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign hs          = hsync_q;
  assign vs          = vsync_q;
  assign hs_d        = hsync_dly_q;
  assign vs_d        = vsync_dly_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default timing, a tiny raster (CLK_DIV=2, active-high sync), and CLK_DIV=1.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       d_pen, d_blank, d_hs, d_vs, d_hsd, d_vsd, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_pen, s_blank, s_hs, s_vs, s_hsd, s_vsd, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic       o_pen, o_blank, o_hs, o_vs, o_hsd, o_vsd, o_ls, o_fs;
  logic [9:0] o_x, o_y;
`ifdef FRAME_CNT_EN
  logic [15:0] d_fc, s_fc, o_fc;
`endif

  vga_timing_gen u_def (
    .CLK(clk), .Reset_n(rst_n), .pixel_en(d_pen), .DrawX(d_x), .DrawY(d_y),
    .blank(d_blank), .hs(d_hs), .vs(d_vs), .hs_d(d_hsd), .vs_d(d_vsd),
    .line_start(d_ls), .frame_start(d_fs)
`ifdef FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(2), .SYNC_ACTIVE(1'b1)
  ) u_sml (
    .CLK(clk), .Reset_n(rst_n), .pixel_en(s_pen), .DrawX(s_x), .DrawY(s_y),
    .blank(s_blank), .hs(s_hs), .vs(s_vs), .hs_d(s_hsd), .vs_d(s_vsd),
    .line_start(s_ls), .frame_start(s_fs)
`ifdef FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  vga_timing_gen #(.CLK_DIV(1)) u_one (
    .CLK(clk), .Reset_n(rst_n), .pixel_en(o_pen), .DrawX(o_x), .DrawY(o_y),
    .blank(o_blank), .hs(o_hs), .vs(o_vs), .hs_d(o_hsd), .vs_d(o_vsd),
    .line_start(o_ls), .frame_start(o_fs)
`ifdef FRAME_CNT_EN
    , .frame_cnt(o_fc)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst_n;
    int   cycles;
    int   x;
    int   y;
    logic blank;
    logic hs;
    logic vs;
    logic pen;
    logic ls;
    logic fs;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // Small raster: H_TOTAL=15 (visible 0..7, sync 10..12), V_TOTAL=8 (visible 0..3, sync 5..6).
    // After edge k (k>=1) pixel n=(k-1)/2; pixel_en=1 on even k.
    vecs[0]  = '{1'b0,  5,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1,  1,  0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b1,  1,  0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1,  1,  1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1,  1,  1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 13,  8, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1,  4, 10, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1,  6, 13, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1,  4,  0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1,  1,  0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 89,  0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 30,  0, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 24, 12, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 36,  0, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 28, 14, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1,  2,  0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{1'b1,  1,  0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Default timing reset values and one full line (CLK_DIV=2), plus CLK_DIV=1 line.
    begin
      int strobes = 0, hs_low = 0, hs_x = -1, bl_x = -1, maxx = 0;
      int hd_bad = 0, vd_bad = 0, o_zero = 0, d_ls2 = -1, o_ls2 = -1;
      logic prev_hs, prev_vs, prev_blank;
      rst_n = 1'b0;
      step(5);
      check("rst.x", d_x, 0);       check("rst.y", d_y, 0);
      check("rst.blank", d_blank, 0); check("rst.hs", d_hs, 1);
      check("rst.vs", d_vs, 1);     check("rst.hs_d", d_hsd, 1);
      check("rst.vs_d", d_vsd, 1);  check("rst.pen", d_pen, 0);
      check("rst.ls", d_ls, 0);     check("rst.fs", d_fs, 0);
      check("rst1.x", o_x, 0);      check("rst1.y", o_y, 0);
      check("rst1.blank", o_blank, 0); check("rst1.hs", o_hs, 1);
      check("rst1.vs", o_vs, 1);    check("rst1.hs_d", o_hsd, 1);
      check("rst1.vs_d", o_vsd, 1); check("rst1.pen", o_pen, 0);
      check("rst1.ls", o_ls, 0);    check("rst1.fs", o_fs, 0);
      prev_hs = d_hs; prev_vs = d_vs; prev_blank = d_blank;
      rst_n = 1'b1;
      for (int cyc = 1; cyc <= 2000; cyc++) begin
        step(1);
        if (cyc == 1) begin
          check("rel.blank", d_blank, 1); check("rel.pen", d_pen, 0);
          check("rel.ls", d_ls, 1);       check("rel.fs", d_fs, 1);
          check("rel1.pen", o_pen, 1);    check("rel1.ls", o_ls, 1);
        end
        if (cyc == 2) check("rel.pen2", d_pen, 1);
        if (cyc > 1 && d_ls) begin
          d_ls2 = cyc;
          break;
        end
        if (d_pen) strobes++;
        if (d_pen && !d_hs) hs_low++;
        if (!d_hs && prev_hs && hs_x < 0) hs_x = int'(d_x);
        if (!d_blank && prev_blank && bl_x < 0) bl_x = int'(d_x);
        if (d_hsd !== prev_hs) hd_bad++;
        if (d_vsd !== prev_vs) vd_bad++;
        if (int'(d_x) > maxx) maxx = int'(d_x);
        if (!o_pen) o_zero++;
        if (cyc > 1 && o_ls && o_ls2 < 0) o_ls2 = cyc;
        prev_hs = d_hs; prev_vs = d_vs; prev_blank = d_blank;
      end
      check("line.period_clk", d_ls2, 1601);
      check("line.strobes", strobes, 800);
      check("line.hs_low", hs_low, 96);
      check("line.hs_start_x", hs_x, 656);
      check("line.blank_fall_x", bl_x, 640);
      check("line.max_x", maxx, 799);
      check("line.hs_d_align", hd_bad, 0);
      check("line.vs_d_align", vd_bad, 0);
      check("div1.pen_gaps", o_zero, 0);
      check("div1.line_clk", o_ls2, 801);
    end

    // Table-driven vectors on the small raster.
    for (int i = 0; i < 17; i++) begin
      rst_n = vecs[i].rst_n;
      step(vecs[i].cycles);
      check($sformatf("v%0d.x", i), s_x, vecs[i].x);
      check($sformatf("v%0d.y", i), s_y, vecs[i].y);
      check($sformatf("v%0d.blank", i), s_blank, vecs[i].blank);
      check($sformatf("v%0d.hs", i), s_hs, vecs[i].hs);
      check($sformatf("v%0d.vs", i), s_vs, vecs[i].vs);
      check($sformatf("v%0d.pen", i), s_pen, vecs[i].pen);
      check($sformatf("v%0d.ls", i), s_ls, vecs[i].ls);
      check($sformatf("v%0d.fs", i), s_fs, vecs[i].fs);
    end

    // Frame timing on the small raster: 15*8*2 = 240 CLK per frame.
    begin
      int fs_n = 0, vs_bad = 0, bl_bad = 0, hd_bad = 0, vd_bad = 0;
      int fs_cyc[4] = '{0, 0, 0, 0};
      logic prev_hs, prev_vs, exp_vs;
      rst_n = 1'b0;
      step(3);
      prev_hs = s_hs; prev_vs = s_vs;
      rst_n = 1'b1;
      for (int cyc = 1; cyc <= 1000; cyc++) begin
        step(1);
        if (s_hsd !== prev_hs) hd_bad++;
        if (s_vsd !== prev_vs) vd_bad++;
        exp_vs = (s_y >= 10'd5 && s_y <= 10'd6);
        if (s_vs !== exp_vs) vs_bad++;
        if (s_y >= 10'd4 && s_blank) bl_bad++;
        if (s_fs) begin
          fs_cyc[fs_n] = cyc;
          fs_n++;
          if (fs_n == 4) break;
        end
        prev_hs = s_hs; prev_vs = s_vs;
      end
      check("frame.count", fs_n, 4);
      check("frame.first", fs_cyc[0], 1);
      check("frame.period1", fs_cyc[1] - fs_cyc[0], 240);
      check("frame.period2", fs_cyc[2] - fs_cyc[1], 240);
      check("frame.vs_window", vs_bad, 0);
      check("frame.blank_lower", bl_bad, 0);
      check("frame.hs_d_align", hd_bad, 0);
      check("frame.vs_d_align", vd_bad, 0);
`ifdef FRAME_CNT_EN
      check("frame.cnt", s_fc, 3);
`endif
    end

    // Asynchronous reset mid-frame, asserted between edges.
    begin
      int found = 0;
      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      for (int cyc = 1; cyc <= 400; cyc++) begin
        step(1);
        if (s_x == 10'd5 && s_y == 10'd3) begin
          found = 1;
          break;
        end
      end
      check("mid.reached", found, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid.x", s_x, 0);         check("mid.y", s_y, 0);
      check("mid.blank", s_blank, 0); check("mid.hs", s_hs, 0);
      check("mid.vs", s_vs, 0);       check("mid.pen", s_pen, 0);
      check("mid.ls", s_ls, 0);       check("mid.fs", s_fs, 0);
      check("mid.def_hs", d_hs, 1);
      step(2);
      rst_n = 1'b1;
      step(1);
      check("mid.rel_fs", s_fs, 1);   check("mid.rel_ls", s_ls, 1);
      check("mid.rel_x", s_x, 0);     check("mid.rel_y", s_y, 0);
      check("mid.rel_blank", s_blank, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
